instr_register_pipe: RTL

- Parametrised successor of the lab instruction register.
- Stores DEPTH instruction entries (opcode, signed operand_a/operand_b), each with a result field.
- A registered one-stage ALU fills the result field one cycle after the write.
- Adds an auto-increment write mode, a registered read port with a valid flag, and divide-by-zero reporting; sits as DUT under the lab test harness.

---
 rtl/instr_register_pipe_if.sv | 61 ++++++
 rtl/instr_register_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_register_pipe_if.sv
// rtl/instr_register_pipe_if.sv - write/read/status bundle for instr_register_pipe
//
// Purpose: groups every non-clock/reset signal of instr_register_pipe.
// Parameters: OP_W (operand width), DEPTH (entry count); AW = $clog2(DEPTH).
// Modports:
//   master - drives load_en, wr_auto, write_pointer, opcode, operand_a,
//            operand_b, rd_en, read_pointer; observes all read/status outputs.
//   slave  - the register file itself (mirror of master).
// Optional: INSTR_REG_STATS_EN adds stat_wr_cnt, stat_rd_cnt, stat_div_err_cnt.

interface instr_register_pipe_if #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OP_W;

    logic                   load_en;
    logic                   wr_auto;
    logic [AW-1:0]          write_pointer;
    logic [2:0]             opcode;
    logic signed [OP_W-1:0] operand_a;
    logic signed [OP_W-1:0] operand_b;
    logic                   rd_en;
    logic [AW-1:0]          read_pointer;

    logic                   rd_valid;
    logic [2:0]             rd_opcode;
    logic signed [OP_W-1:0] rd_operand_a;
    logic signed [OP_W-1:0] rd_operand_b;
    logic signed [RW-1:0]   rd_res;
    logic                   rd_res_valid;
    logic                   rd_div_err;
    logic [AW-1:0]          wr_ptr;
    logic                   busy;
`ifdef INSTR_REG_STATS_EN
    logic [15:0]            stat_wr_cnt;
    logic [15:0]            stat_rd_cnt;
    logic [15:0]            stat_div_err_cnt;
`endif

    modport master (
        output load_en, wr_auto, write_pointer, opcode, operand_a, operand_b,
               rd_en, read_pointer,
        input  rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_res,
               rd_res_valid, rd_div_err, wr_ptr, busy
`ifdef INSTR_REG_STATS_EN
        , input stat_wr_cnt, stat_rd_cnt, stat_div_err_cnt
`endif
    );

    modport slave (
        input  load_en, wr_auto, write_pointer, opcode, operand_a, operand_b,
               rd_en, read_pointer,
        output rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_res,
               rd_res_valid, rd_div_err, wr_ptr, busy
`ifdef INSTR_REG_STATS_EN
        , output stat_wr_cnt, stat_rd_cnt, stat_div_err_cnt
`endif
    );
endinterface

// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - DEPTH-entry instruction register with one-stage registered ALU
//
// Purpose: stores {opcode, operand_a, operand_b} per entry; a registered ALU
// stage computes the result on the write edge and commits it into the entry
// on the following edge. Registered read-old read port with valid flag.
// Ports:
//   clk   - single rising-edge clock
//   reset - asynchronous, active-high; clears all state
//   bus   - instr_register_pipe_if.slave (write request, read request,
//           registered read data, wr_ptr, busy)
// Optional: define INSTR_REG_STATS_EN for saturating 16-bit write/read/
// div-error counters on the interface.

module instr_register_pipe #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    instr_register_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OP_W;
    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    logic [2:0]             mem_opcode    [DEPTH];
    logic signed [OP_W-1:0] mem_a         [DEPTH];
    logic signed [OP_W-1:0] mem_b         [DEPTH];
    logic signed [RW-1:0]   mem_res       [DEPTH];
    logic                   mem_res_valid [DEPTH];
    logic                   mem_div_err   [DEPTH];

    logic [AW-1:0]          wr_ptr_q;
    logic                   alu_valid_q;
    logic [AW-1:0]          alu_addr_q;
    logic signed [RW-1:0]   alu_res_q;
    logic                   alu_err_q;

    logic                   rd_valid_q;
    logic [2:0]             rd_opcode_q;
    logic signed [OP_W-1:0] rd_a_q;
    logic signed [OP_W-1:0] rd_b_q;
    logic signed [RW-1:0]   rd_res_q;
    logic                   rd_res_valid_q;
    logic                   rd_div_err_q;

    logic [AW-1:0]          wr_addr;
    logic                   wr_accept;
    logic                   rd_in_range;
    logic                   commit;
    logic signed [RW-1:0]   ext_a;
    logic signed [RW-1:0]   ext_b;
    logic signed [RW-1:0]   alu_res_d;
    logic                   alu_err_d;

    always_comb begin
        wr_addr     = bus.wr_auto ? wr_ptr_q : bus.write_pointer;
        wr_accept   = bus.load_en && ({1'b0, wr_addr} < DEPTH_V);
        rd_in_range = {1'b0, bus.read_pointer} < DEPTH_V;
        // A new write to the address the ALU stage is about to commit makes
        // that result stale: drop it so res_valid stays low until the new
        // result commits one edge later.
        commit      = alu_valid_q && !(wr_accept && (wr_addr == alu_addr_q));
    end

    // Operands are sign-extended to the full result width first; at 2*OP_W
    // bits ADD/SUB/MULT cannot overflow and MIN / -1 is representable.
    always_comb begin
        ext_a     = {{OP_W{bus.operand_a[OP_W-1]}}, bus.operand_a};
        ext_b     = {{OP_W{bus.operand_b[OP_W-1]}}, bus.operand_b};
        alu_res_d = '0;
        alu_err_d = 1'b0;
        case (bus.opcode)
            OP_ZERO:  alu_res_d = '0;
            OP_PASSA: alu_res_d = ext_a;
            OP_PASSB: alu_res_d = ext_b;
            OP_ADD:   alu_res_d = ext_a + ext_b;
            OP_SUB:   alu_res_d = ext_a - ext_b;
            OP_MULT:  alu_res_d = ext_a * ext_b;
            OP_DIV: begin
                if (bus.operand_b == '0) alu_err_d = 1'b1;
                else                     alu_res_d = ext_a / ext_b;
            end
            OP_MOD: begin
                if (bus.operand_b == '0) alu_err_d = 1'b1;
                else                     alu_res_d = ext_a % ext_b;
            end
            default: alu_res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_opcode[i]    <= '0;
                mem_a[i]         <= '0;
                mem_b[i]         <= '0;
                mem_res[i]       <= '0;
                mem_res_valid[i] <= 1'b0;
                mem_div_err[i]   <= 1'b0;
            end
            wr_ptr_q       <= '0;
            alu_valid_q    <= 1'b0;
            alu_addr_q     <= '0;
            alu_res_q      <= '0;
            alu_err_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_opcode_q    <= '0;
            rd_a_q         <= '0;
            rd_b_q         <= '0;
            rd_res_q       <= '0;
            rd_res_valid_q <= 1'b0;
            rd_div_err_q   <= 1'b0;
        end else begin
            if (commit) begin
                mem_res[alu_addr_q]       <= alu_res_q;
                mem_div_err[alu_addr_q]   <= alu_err_q;
                mem_res_valid[alu_addr_q] <= 1'b1;
            end
            if (wr_accept) begin
                mem_opcode[wr_addr]    <= bus.opcode;
                mem_a[wr_addr]         <= bus.operand_a;
                mem_b[wr_addr]         <= bus.operand_b;
                mem_res_valid[wr_addr] <= 1'b0;
                alu_addr_q             <= wr_addr;
                alu_res_q              <= alu_res_d;
                alu_err_q              <= alu_err_d;
            end
            alu_valid_q <= wr_accept;

            if (bus.load_en && bus.wr_auto)
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);

            // Array reads here see pre-edge contents, giving read-old order.
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if (rd_in_range) begin
                    rd_opcode_q    <= mem_opcode[bus.read_pointer];
                    rd_a_q         <= mem_a[bus.read_pointer];
                    rd_b_q         <= mem_b[bus.read_pointer];
                    rd_res_q       <= mem_res[bus.read_pointer];
                    rd_res_valid_q <= mem_res_valid[bus.read_pointer];
                    rd_div_err_q   <= mem_div_err[bus.read_pointer];
                end else begin
                    rd_opcode_q    <= '0;
                    rd_a_q         <= '0;
                    rd_b_q         <= '0;
                    rd_res_q       <= '0;
                    rd_res_valid_q <= 1'b0;
                    rd_div_err_q   <= 1'b0;
                end
            end
        end
    end

    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_opcode    = rd_opcode_q;
    assign bus.rd_operand_a = rd_a_q;
    assign bus.rd_operand_b = rd_b_q;
    assign bus.rd_res       = rd_res_q;
    assign bus.rd_res_valid = rd_res_valid_q;
    assign bus.rd_div_err   = rd_div_err_q;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.busy         = alu_valid_q;

`ifdef INSTR_REG_STATS_EN
    logic [15:0] stat_wr_q;
    logic [15:0] stat_rd_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_wr_q  <= '0;
            stat_rd_q  <= '0;
            stat_err_q <= '0;
        end else begin
            if (wr_accept && (stat_wr_q != 16'hFFFF))
                stat_wr_q <= stat_wr_q + 16'd1;
            if (bus.rd_en && (stat_rd_q != 16'hFFFF))
                stat_rd_q <= stat_rd_q + 16'd1;
            if (commit && alu_err_q && (stat_err_q != 16'hFFFF))
                stat_err_q <= stat_err_q + 16'd1;
        end
    end

    assign bus.stat_wr_cnt      = stat_wr_q;
    assign bus.stat_rd_cnt      = stat_rd_q;
    assign bus.stat_div_err_cnt = stat_err_q;
`endif

endmodule
